// File: rtl/fetch_decode_buffer_if.sv
// Fetch/decode handshake bundle for the fetch_decode_buffer.
//   master : the surrounding pipeline (drives fetch inputs, flush, decode ready)
//   slave  : the buffer itself
// Fetch side  : in_valid, in_inst, in_pc -> buffer ; in_ready <- buffer
// Decode side : out_valid, out_inst, out_pc, out_pc4 <- buffer ; out_ready -> buffer
// Control     : flush (taken branch) -> buffer
interface fetch_decode_buffer_if;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic        out_ready;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_pc4
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_pc4
    );
endinterface

// File: rtl/fetch_decode_buffer.sv
// Two-entry skid FIFO between fetch and decode, holding {inst, pc} pairs.
// Ports:
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset of control state
//   bus        : fetch/decode handshake bundle (slave side)
//   bubble_cnt : saturating count of cycles decode was ready but got nothing
// in_ready depends only on registered occupancy, so there is no combinational
// path from out_ready or flush back to the fetch stage.
module fetch_decode_buffer #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_decode_buffer_if.slave bus,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic [31:0] inst_mem [2];
    logic [31:0] pc_mem   [2];

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] bubble_q, bubble_d;

    logic push;
    logic pop;

    assign bus.in_ready  = ~count_q[1];
    assign bus.out_valid = (count_q != 2'd0);

    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    assign bus.out_inst = bus.out_valid ? inst_mem[rd_ptr_q] : NOP_INST;
    assign bus.out_pc   = bus.out_valid ? pc_mem[rd_ptr_q] : 32'h0;
    assign bus.out_pc4  = bus.out_pc + 32'd4;
    assign bubble_cnt   = bubble_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        bubble_d = bubble_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (bus.flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
        if (!bus.out_valid && bus.out_ready && !bus.flush && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            bubble_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            bubble_q <= bubble_d;
        end
    end

    // Data storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q] <= bus.in_inst;
            pc_mem[wr_ptr_q]   <= bus.in_pc;
        end
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
module tb_fetch_decode_buffer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    logic [15:0] bubble_cnt;
    logic [1:0]  small_bubble;

    int checks;
    int errors;

    fetch_decode_buffer_if bus ();
    fetch_decode_buffer_if small_bus ();

    fetch_decode_buffer #(
        .NOP_INST (NOP),
        .CNT_W    (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .bubble_cnt (bubble_cnt)
    );

    // Narrow counter instance: decode always ready, fetch never valid.
    assign small_bus.in_valid  = 1'b0;
    assign small_bus.in_inst   = 32'h0;
    assign small_bus.in_pc     = 32'h0;
    assign small_bus.flush     = 1'b0;
    assign small_bus.out_ready = 1'b1;

    fetch_decode_buffer #(
        .NOP_INST (NOP),
        .CNT_W    (2)
    ) dut_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (small_bus),
        .bubble_cnt (small_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle; inputs are changed after this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        #12;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_inst", bus.out_inst, NOP);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_pc4", bus.out_pc4, 32'h4);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("rst_bubble", {16'b0, bubble_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Bubbles: five idle cycles with decode ready.
        repeat (5) step();
        check("bubble_5", {16'b0, bubble_cnt}, 32'd5);
        check("bubble_sat", {30'b0, small_bubble}, 32'd3);

        // Streaming: one-cycle latency, occupancy stays at one.
        drive(1'b1, 32'h2001_0005, 32'h0, 1'b1, 1'b0);
        step();
        check("s1_valid", {31'b0, bus.out_valid}, 32'd1);
        check("s1_inst", bus.out_inst, 32'h2001_0005);
        check("s1_pc4", bus.out_pc4, 32'h4);
        drive(1'b1, 32'h2002_0007, 32'h4, 1'b1, 1'b0);
        step();
        check("s2_inst", bus.out_inst, 32'h2002_0007);
        check("s2_pc4", bus.out_pc4, 32'h8);
        check("s2_in_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("s3_valid", {31'b0, bus.out_valid}, 32'd0);
        check("s3_bubble", {16'b0, bubble_cnt}, 32'd6);
        bus.out_ready = 1'b0;

        // Stall / full.
        drive(1'b1, 32'hAAAA_0001, 32'h100, 1'b0, 1'b0);
        step();
        check("st_a_inst", bus.out_inst, 32'hAAAA_0001);
        check("st_a_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b1, 32'hBBBB_0002, 32'h104, 1'b0, 1'b0);
        step();
        check("st_b_ready", {31'b0, bus.in_ready}, 32'd0);
        check("st_b_head", bus.out_inst, 32'hAAAA_0001);
        drive(1'b1, 32'hCCCC_0003, 32'h108, 1'b0, 1'b0);
        step();
        check("st_c_ready", {31'b0, bus.in_ready}, 32'd0);
        check("st_c_head", bus.out_inst, 32'hAAAA_0001);
        check("st_c_pc", bus.out_pc, 32'h100);
        bus.out_ready = 1'b1;
        step();
        check("dr_b_inst", bus.out_inst, 32'hBBBB_0002);
        check("dr_b_pc", bus.out_pc, 32'h104);
        check("dr_b_ready", {31'b0, bus.in_ready}, 32'd1);
        step();
        check("dr_c_inst", bus.out_inst, 32'hCCCC_0003);
        check("dr_c_pc4", bus.out_pc4, 32'h10C);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("dr_empty", {31'b0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Flush with a full buffer and an incoming word.
        drive(1'b1, 32'hDDDD_0004, 32'hC, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hEEEE_0005, 32'h10, 1'b0, 1'b0);
        step();
        check("fl_full", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b1, 32'hFFFF_0006, 32'h20, 1'b1, 1'b1);
        step();
        check("fl_valid", {31'b0, bus.out_valid}, 32'd0);
        check("fl_inst", bus.out_inst, NOP);
        check("fl_in_ready", {31'b0, bus.in_ready}, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        step();
        check("fl_bubble_hold", {16'b0, bubble_cnt}, 32'd6);
        check("fl_still_empty", {31'b0, bus.out_valid}, 32'd0);
        drive(1'b1, 32'h1234_5678, 32'h14, 1'b1, 1'b0);
        step();
        check("fl_next_inst", bus.out_inst, 32'h1234_5678);
        check("fl_next_pc", bus.out_pc, 32'h14);
        check("fl_next_pc4", bus.out_pc4, 32'h18);
        check("fl_next_bubble", {16'b0, bubble_cnt}, 32'd7);

        // PC wrap; also push-with-pop at count 1 makes the new word the head.
        drive(1'b1, 32'h8765_4321, 32'hFFFF_FFFC, 1'b1, 1'b0);
        step();
        check("wrap_inst", bus.out_inst, 32'h8765_4321);
        check("wrap_pc", bus.out_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", bus.out_pc4, 32'h0);

        // Fill to two, then reset between edges.
        drive(1'b1, 32'h5555_0009, 32'h30, 1'b0, 1'b0);
        step();
        check("ar_full", {31'b0, bus.in_ready}, 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", {31'b0, bus.out_valid}, 32'd0);
        check("ar_inst", bus.out_inst, NOP);
        check("ar_pc", bus.out_pc, 32'h0);
        check("ar_pc4", bus.out_pc4, 32'h4);
        check("ar_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("ar_bubble", {16'b0, bubble_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h7777_000A, 32'h40, 1'b1, 1'b0);
        step();
        check("ar_first_inst", bus.out_inst, 32'h7777_000A);
        check("ar_first_pc", bus.out_pc, 32'h40);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        check("ar_no_stale", {31'b0, bus.out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
FETCH_DECODE_BUFFER -- requirements
Module: fetch_decode_buffer

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0000, meaning the instruction word driven on out_inst whenever out_valid=0.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of bubble_cnt.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  the fetch stage presents an instruction this cycle.
REQ-006 SHALL have port in_inst  input  32  fetched instruction word.
REQ-007 SHALL have port in_pc  input  32  PC of in_inst.
REQ-008 SHALL have port in_ready  output  1  the buffer accepts in_inst this cycle.
REQ-009 SHALL have port flush  input  1  taken branch (PCsrc=1): discard all buffered and incoming instructions.
REQ-010 SHALL have port out_valid  output  1  out_inst/out_pc/out_pc4 hold a valid instruction for decode.
REQ-011 SHALL have port out_inst  output  32  instruction at buffer head.
REQ-012 SHALL have port out_pc  output  32  PC of the head instruction.
REQ-013 SHALL have port out_pc4  output  32  out_pc + 4.
REQ-014 SHALL have port out_ready  input  1  decode consumes the head this cycle; 0 = decode stall.
REQ-015 SHALL have port bubble_cnt  output  CNT_W  saturating count of bubble cycles delivered to decode.

Function
REQ-016 SHALL implement a 2-entry FIFO of {inst, pc} with a 2-bit occupancy count (0..2) and 1-bit read/write pointers.
REQ-017 SHALL drive in_ready = (count < 2), from registered state only; no combinational path from out_ready or flush to in_ready.
REQ-018 SHALL push when in_valid & in_ready & !flush; push with in_valid=0 or in_ready=0 SHALL leave state unchanged.
REQ-019 SHALL pop when out_valid & out_ready & !flush.
REQ-020 SHALL drive out_valid = (count != 0); out_inst/out_pc SHALL come from the head entry when valid, else NOP_INST and 32'h0.
REQ-021 SHALL drive out_pc4 = out_pc + 32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-022 SHALL have latency exactly one cycle: an instruction pushed at edge N into an empty buffer is on out_* after edge N.
REQ-023 SHALL, on simultaneous push and pop with count=1, keep count=1 and make the pushed entry the new head.
REQ-024 SHALL, with count=2, refuse pushes (in_ready=0) even if out_ready=1 that cycle; the pop frees one slot for the next cycle.
REQ-025 SHALL, when flush=1, set count=0 and both pointers to 0 at the next edge, ignoring any same-cycle push or pop.
REQ-026 SHALL preserve order: instructions leave in the order accepted, no loss or duplication absent flush.
REQ-027 SHALL increment bubble_cnt by 1 each cycle with out_valid=0, out_ready=1, flush=0, saturating at 2^CNT_W-1.
REQ-028 SHALL not change bubble_cnt in a flush cycle.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously set count=0, pointers=0, bubble_cnt=0, so out_valid=0, out_inst=NOP_INST, out_pc=0, out_pc4=4, in_ready=1.
REQ-030 SHALL, on reset mid-operation, discard all buffered entries; the first push after rst_n rises is the first instruction delivered.
REQ-031 SHALL leave FIFO data storage unreset; only control state is reset.

Verification
REQ-032 SHALL verify streaming: push 0x2001_0005@0x0, 0x2002_0007@0x4, out_ready=1 -> each appears one cycle later, out_pc4=0x4 then 0x8, count never >1.
REQ-033 SHALL verify stall/full: out_ready=0, push 3 words A,B,C -> A,B accepted, in_ready=0 on C, out_inst holds A; out_ready=1 -> A,B,C delivered in order, no loss.
REQ-034 SHALL verify flush: count=2, flush=1 with in_valid=1 and out_ready=1 -> next cycle out_valid=0, out_inst=NOP_INST, incoming word dropped; next push at PC 0x14 delivered.
REQ-035 SHALL verify bubbles: out_ready=1, in_valid=0 for 5 cycles after reset -> bubble_cnt=5; with CNT_W=2 -> sticks at 3.
REQ-036 SHALL verify async reset: assert rst_n=0 between edges with count=2 -> outputs take reset values immediately, before the next clk edge.
REQ-037 SHALL verify PC wrap: push in_pc=0xFFFF_FFFC -> out_pc4=0x0000_0000.
